// File: rtl/simd_issue_queue_if.sv
// ============================================================================
// Module      : simd_issue_queue_if
// Description : Bundle of the producer handshake, ALU issue bus and result
//               qualifier signals of the SIMD issue queue.
//               master : producer/ALU side (drives s_*, stall, flush)
//               slave  : queue side (drives s_ready, issue_*, res_*, count)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simd_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic               s_valid;
  logic               s_ready;
  logic [15:0]        s_inst;
  logic [255:0]       s_A;
  logic [255:0]       s_B;
  logic               stall;
  logic               flush;
  logic [15:0]        issue_inst;
  logic [255:0]       issue_A;
  logic [255:0]       issue_B;
  logic               res_valid;
  logic [SEQ_W-1:0]   res_seq;
  logic [c_CNT_W-1:0] count;

  modport master (
    output s_valid, s_inst, s_A, s_B, stall, flush,
    input  s_ready, issue_inst, issue_A, issue_B, res_valid, res_seq, count
  );

  modport slave (
    input  s_valid, s_inst, s_A, s_B, stall, flush,
    output s_ready, issue_inst, issue_A, issue_B, res_valid, res_seq, count
  );
endinterface

`default_nettype wire

// File: rtl/simd_issue_queue.sv
// ============================================================================
// Module      : simd_issue_queue
// Description : Circular-buffer issue queue between an instruction/operand
//               producer and a SIMD ALU. Entries issue in order, one per
//               cycle, never in the cycle they are pushed. Issue buses are
//               forced to zero (ALU NOP) whenever nothing issues. res_valid
//               and res_seq are registered to line up with the ALU's
//               registered result one cycle after issue.
// Ports       : clk - clock, rising edge
//               rst - asynchronous, active-low reset
//               q   - simd_issue_queue_if.slave (handshake, issue, result)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_issue_queue #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  simd_issue_queue_if.slave  q
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  // Entry storage; deliberately not reset.
  logic [15:0]        r_inst [DEPTH];
  logic [255:0]       r_a    [DEPTH];
  logic [255:0]       r_b    [DEPTH];

  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [SEQ_W-1:0]   r_seq;
  logic [SEQ_W-1:0]   r_res_seq;
  logic               r_res_valid;

  logic               w_ready;
  logic               w_push;
  logic               w_fire;

  // Ready depends only on occupancy and flush, so a full queue refuses a
  // push even in a cycle where the head issues.
  assign w_ready = (r_count < c_CNT_W'(DEPTH)) && !q.flush;
  assign w_push  = q.s_valid && w_ready;
  assign w_fire  = (r_count != '0) && !q.stall && !q.flush;

  assign q.s_ready    = w_ready;
  assign q.count      = r_count;
  assign q.res_valid  = r_res_valid;
  assign q.res_seq    = r_res_seq;

  // Head entry is presented only while issuing; otherwise a zero word is a NOP.
  assign q.issue_inst = w_fire ? r_inst[r_rd_ptr] : '0;
  assign q.issue_A    = w_fire ? r_a[r_rd_ptr]    : '0;
  assign q.issue_B    = w_fire ? r_b[r_rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_wr_ptr] <= q.s_inst;
      r_a[r_wr_ptr]    <= q.s_A;
      r_b[r_wr_ptr]    <= q.s_B;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_seq       <= '0;
      r_res_seq   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      // w_fire is already low during flush, so this also clears on flush.
      r_res_valid <= w_fire;
      if (w_fire) begin
        r_res_seq <= r_seq;
        r_seq     <= r_seq + SEQ_W'(1);
      end
      if (q.flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        // DEPTH is a power of two, so pointer wrap is natural overflow.
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_fire) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_fire);
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_simd_issue_queue.sv
// ============================================================================
// Module      : tb_simd_issue_queue
// Description : Self-checking bench for simd_issue_queue. A queue-based model
//               of the entries plus a sequence counter predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simd_issue_queue;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  simd_issue_queue_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) vif ();
  simd_issue_queue #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (vif)
  );

  typedef struct {
    logic [15:0]  inst;
    logic [255:0] a;
    logic [255:0] b;
  } ent_t;

  ent_t m_q[$];
  int   m_seq;
  logic m_rv;
  int   m_rseq;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic v, input logic [15:0] inst,
                       input logic [255:0] a, input logic [255:0] b,
                       input logic st, input logic fl);
    vif.s_valid = v; vif.s_inst = inst; vif.s_A = a; vif.s_B = b;
    vif.stall = st; vif.flush = fl;
  endtask

  task automatic model_reset();
    m_q.delete(); m_seq = 0; m_rv = 1'b0; m_rseq = 0;
  endtask

  function automatic logic exp_fire();
    return (m_q.size() > 0) && !vif.stall && !vif.flush;
  endfunction
  function automatic logic [15:0]  exp_inst(); return exp_fire() ? m_q[0].inst : '0; endfunction
  function automatic logic [255:0] exp_a();    return exp_fire() ? m_q[0].a    : '0; endfunction
  function automatic logic [255:0] exp_b();    return exp_fire() ? m_q[0].b    : '0; endfunction
  function automatic logic exp_ready();
    return (m_q.size() < DEPTH) && !vif.flush;
  endfunction

  // One clock: model sees the inputs as they stand before the edge.
  task automatic tick();
    logic rdy, fire, push;
    ent_t e;
    rdy  = exp_ready();
    fire = exp_fire();
    push = vif.s_valid && rdy;
    e.inst = vif.s_inst; e.a = vif.s_A; e.b = vif.s_B;
    @(posedge clk);
    if (vif.flush) begin
      m_q.delete();
      m_rv = 1'b0;
    end else begin
      m_rv = fire;
      if (fire) begin
        m_rseq = m_seq;
        m_seq  = (m_seq + 1) % (1 << SEQ_W);
        void'(m_q.pop_front());
      end
      if (push) m_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b1, 16'hABCD, rnd256(), rnd256(), 1'b0, 1'b0);
    #12;
    n_cmp++; if (vif.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", vif.count); end
    n_cmp++; if (vif.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", vif.s_ready); end
    n_cmp++; if (vif.issue_inst !== 16'h0) begin n_err++; $display("FAIL reset_issue: got %h expected 0000", vif.issue_inst); end
    n_cmp++; if (vif.res_valid !== 1'b0 || vif.res_seq !== 8'd0) begin n_err++; $display("FAIL reset_res: got %b/%0d expected 0/0", vif.res_valid, vif.res_seq); end
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 16'h1123, 256'd1, 256'd2, 1'b0, 1'b0);
    #1;
    n_cmp++; if (vif.issue_inst !== 16'h0) begin n_err++; $display("FAIL single_nobypass: got %h expected 0000", vif.issue_inst); end
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (vif.issue_inst !== 16'h1123 || vif.issue_A !== 256'd1 || vif.issue_B !== 256'd2) begin
      n_err++; $display("FAIL single_issue: got %h A=%0d B=%0d expected 1123 A=1 B=2", vif.issue_inst, vif.issue_A, vif.issue_B); end
    tick();
    n_cmp++; if (vif.res_valid !== 1'b1 || vif.res_seq !== 8'd0) begin n_err++; $display("FAIL single_res: got %b/%0d expected 1/0", vif.res_valid, vif.res_seq); end
    n_cmp++; if (vif.count !== 3'd0) begin n_err++; $display("FAIL single_count: got %0d expected 0", vif.count); end
    tick();
    n_cmp++; if (vif.res_valid !== 1'b0) begin n_err++; $display("FAIL single_res_drop: got %b expected 0", vif.res_valid); end
  endtask

  task automatic test_fill();
    logic [255:0] av [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      av[i] = rnd256();
      drive(1'b1, 16'h2000 + 16'(i), av[i], rnd256(), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 16'h2FFF, rnd256(), rnd256(), 1'b1, 1'b0);
    #1;
    n_cmp++; if (vif.count !== 3'd4 || vif.s_ready !== 1'b0 || vif.issue_inst !== 16'h0) begin
      n_err++; $display("FAIL fill_full: got count=%0d ready=%b inst=%h expected 4/0/0000", vif.count, vif.s_ready, vif.issue_inst); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (vif.issue_inst !== 16'h2000 + 16'(i) || vif.issue_A !== av[i]) begin
        n_err++; $display("FAIL fill_order: got %h expected %h", vif.issue_inst, 16'h2000 + 16'(i)); end
      tick();
      n_cmp++; if (vif.res_valid !== 1'b1 || vif.res_seq !== 8'(i)) begin
        n_err++; $display("FAIL fill_seq: got %b/%0d expected 1/%0d", vif.res_valid, vif.res_seq, i); end
    end
  endtask

  task automatic test_full_concurrent();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h3000 + 16'(i), rnd256(), rnd256(), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 16'h3100, rnd256(), rnd256(), 1'b0, 1'b0);
    #1;
    n_cmp++; if (vif.s_ready !== 1'b0 || vif.issue_inst !== 16'h3000) begin
      n_err++; $display("FAIL full_nopush: got ready=%b inst=%h expected 0/3000", vif.s_ready, vif.issue_inst); end
    tick();
    n_cmp++; if (vif.count !== 3'd3) begin n_err++; $display("FAIL full_count: got %0d expected 3", vif.count); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h3101 + 16'(k), rnd256(), rnd256(), 1'b0, 1'b0);
      #1;
      n_cmp++; if (vif.s_ready !== 1'b1 || vif.count !== 3'd3 || vif.issue_inst !== exp_inst()) begin
        n_err++; $display("FAIL full_sustain: got ready=%b count=%0d inst=%h expected 1/3/%h", vif.s_ready, vif.count, vif.issue_inst, exp_inst()); end
      tick();
    end
    n_cmp++; if (vif.count !== 3'd3) begin n_err++; $display("FAIL full_sustain_end: got %0d expected 3", vif.count); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 16'h4000, rnd256(), rnd256(), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h4001 + 16'(i), rnd256(), rnd256(), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 16'h4444, rnd256(), rnd256(), 1'b0, 1'b1);
    #1;
    n_cmp++; if (vif.s_ready !== 1'b0 || vif.issue_inst !== 16'h0 || vif.count !== 3'd3) begin
      n_err++; $display("FAIL flush_cycle: got ready=%b inst=%h count=%0d expected 0/0000/3", vif.s_ready, vif.issue_inst, vif.count); end
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (vif.count !== 3'd0 || vif.res_valid !== 1'b0 || vif.issue_inst !== 16'h0) begin
      n_err++; $display("FAIL flush_after: got count=%0d rv=%b inst=%h expected 0/0/0000", vif.count, vif.res_valid, vif.issue_inst); end
    drive(1'b1, 16'h4555, rnd256(), rnd256(), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (vif.issue_inst !== 16'h4555) begin n_err++; $display("FAIL flush_next_issue: got %h expected 4555", vif.issue_inst); end
    tick();
    n_cmp++; if (vif.res_valid !== 1'b1 || vif.res_seq !== 8'd1) begin
      n_err++; $display("FAIL flush_seq_cont: got %b/%0d expected 1/1", vif.res_valid, vif.res_seq); end
  endtask

  task automatic test_seq_wrap();
    int seen;
    seen = 0;
    do_reset();
    for (int i = 0; i < 258; i++) begin
      drive(i < 257, 16'(i), rnd256(), rnd256(), 1'b0, 1'b0);
      tick();
      if (vif.res_valid === 1'b1) begin
        if (seen == 255) begin
          n_cmp++; if (vif.res_seq !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d expected 255", vif.res_seq); end
        end
        if (seen == 256) begin
          n_cmp++; if (vif.res_seq !== 8'd0) begin n_err++; $display("FAIL wrap_0: got %0d expected 0", vif.res_seq); end
        end
        seen++;
      end
    end
    n_cmp++; if (seen != 257) begin n_err++; $display("FAIL wrap_issue_count: got %0d expected 257", seen); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h5000 + 16'(i), rnd256(), rnd256(), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    #1;
    n_cmp++; if (vif.count !== 3'd2 || vif.res_valid !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: got count=%0d rv=%b expected 2/1", vif.count, vif.res_valid); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (vif.count !== 3'd0 || vif.res_valid !== 1'b0 || vif.issue_inst !== 16'h0 || vif.s_ready !== 1'b1) begin
      n_err++; $display("FAIL areset_immediate: got count=%0d rv=%b inst=%h ready=%b expected 0/0/0000/1", vif.count, vif.res_valid, vif.issue_inst, vif.s_ready); end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 16'h5555, rnd256(), rnd256(), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (vif.res_valid !== 1'b1 || vif.res_seq !== 8'd0) begin
      n_err++; $display("FAIL areset_first_seq: got %b/%0d expected 1/0", vif.res_valid, vif.res_seq); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, 16'($urandom), rnd256(), rnd256(),
            ($urandom % 3) == 0, ($urandom % 16) == 0);
      #1;
      n_cmp++; if (vif.count !== 3'(m_q.size()) || vif.s_ready !== exp_ready()) begin
        n_err++; $display("FAIL rand_occ c=%0d: got count=%0d ready=%b expected %0d/%b", c, vif.count, vif.s_ready, m_q.size(), exp_ready()); end
      n_cmp++; if (vif.issue_inst !== exp_inst() || vif.issue_A !== exp_a() || vif.issue_B !== exp_b()) begin
        n_err++; $display("FAIL rand_issue c=%0d: got inst=%h expected %h (or operand differs)", c, vif.issue_inst, exp_inst()); end
      tick();
      n_cmp++; if (vif.res_valid !== m_rv || vif.res_seq !== SEQ_W'(m_rseq)) begin
        n_err++; $display("FAIL rand_res c=%0d: got %b/%0d expected %b/%0d", c, vif.res_valid, vif.res_seq, m_rv, m_rseq); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_fill();
    test_full_concurrent();
    test_flush();
    test_seq_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
